mor1kx_rf_port_arbiter: RTL and testbench

//  Controller in front of the register-file RAM (single-clock simple dual-port RAM: one write

---
 rtl/mor1kx_rf_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mor1kx_rf_port_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_rf_port_arbiter.sv
// mor1kx_rf_port_arbiter
//   Front end of the register-file RAM (simple dual-port, registered read with
//   write->read bypass). It zero-clears the RF after reset, passes the pipeline's
//   read/write ports through, and shares both RAM ports with a secondary
//   requester (shadow-stack / debug) over a req/ack handshake. A secondary
//   write that keeps losing to pipeline writes eventually stalls the pipeline.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cpu_we_i/waddr_i/wdata_i    pipeline write port
//   cpu_re_i/raddr_i            pipeline read port
//   cpu_stall_o                 pipeline must hold its request while high
//   sec_req_i/we_i/addr_i/wdata_i  secondary request, held until sec_ack_o
//   sec_ack_o                   request accepted this cycle (pulse)
//   sec_rdata_o/sec_rvalid_o    secondary read data with one-cycle valid
//   rf_we_o/waddr_o/wdata_o     RAM write port
//   rf_re_o/raddr_o, rf_rdata_i RAM read port (data one cycle after rf_re_o)
//   busy_o                      high while the zero-clear sequence runs
module mor1kx_rf_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_waddr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  input  logic                  cpu_re_i,
  input  logic [ADDR_WIDTH-1:0] cpu_raddr_i,
  output logic                  cpu_stall_o,
  input  logic                  sec_req_i,
  input  logic                  sec_we_i,
  input  logic [ADDR_WIDTH-1:0] sec_addr_i,
  input  logic [DATA_WIDTH-1:0] sec_wdata_i,
  output logic                  sec_ack_o,
  output logic [DATA_WIDTH-1:0] sec_rdata_o,
  output logic                  sec_rvalid_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  rf_re_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned SW = 8;

  localparam logic [SW-1:0] STARVE_MAX = '1;
  localparam logic [SW-1:0] STARVE_THR = SW'(STARVE_LIMIT);
  localparam logic [AW-1:0] CLR_LAST   = '1;

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_RUN     = 2'd1,
    S_SEC     = 2'd2,
    S_RESTORE = 2'd3
  } state_e;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [AW-1:0] last_raddr_q, last_raddr_d;
  logic [DW-1:0] sec_rdata_q, sec_rdata_d;
  logic          sec_rvalid_q, sec_rvalid_d;
  logic [SW-1:0] starve_inc;

  // Saturating increment of the denied-cycle counter
  assign starve_inc = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      clr_cnt_q    <= '0;
      starve_q     <= '0;
      last_raddr_q <= '0;
      sec_rdata_q  <= '0;
      sec_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      starve_q     <= starve_d;
      last_raddr_q <= last_raddr_d;
      sec_rdata_q  <= sec_rdata_d;
      sec_rvalid_q <= sec_rvalid_d;
    end
  end

  // Next-state and RAM port steering
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    starve_d     = starve_q;
    last_raddr_d = last_raddr_q;
    sec_rdata_d  = sec_rdata_q;
    sec_rvalid_d = 1'b0;
    rf_we_o      = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    rf_re_o      = 1'b0;
    rf_raddr_o   = '0;
    sec_ack_o    = 1'b0;
    cpu_stall_o  = 1'b1;
    busy_o       = 1'b0;

    unique case (state_q)
      S_CLEAR: begin
        busy_o     = 1'b1;
        rf_we_o    = 1'b1;
        rf_waddr_o = clr_cnt_q;
        clr_cnt_d  = clr_cnt_q + AW'(1);
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        cpu_stall_o = 1'b0;
        rf_we_o     = cpu_we_i;
        rf_waddr_o  = cpu_waddr_i;
        rf_wdata_o  = cpu_wdata_i;
        rf_re_o     = cpu_re_i;
        rf_raddr_o  = cpu_raddr_i;
        if (cpu_re_i) begin
          last_raddr_d = cpu_raddr_i;
        end
        if (!sec_req_i) begin
          starve_d = '0;
        end else if (!sec_we_i) begin
          // A secondary read disturbs RAM dout, so it always goes through a stall
          state_d = S_SEC;
        end else if (!cpu_we_i) begin
          // Write port is free: slip the secondary write in without stalling
          rf_we_o    = 1'b1;
          rf_waddr_o = sec_addr_i;
          rf_wdata_o = sec_wdata_i;
          sec_ack_o  = 1'b1;
          starve_d   = '0;
        end else begin
          starve_d = starve_inc;
          if (starve_inc >= STARVE_THR) begin
            state_d = S_SEC;
          end
        end
      end

      S_SEC: begin
        sec_ack_o = sec_req_i;
        starve_d  = '0;
        state_d   = S_RUN;
        if (sec_req_i && sec_we_i) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = sec_addr_i;
          rf_wdata_o = sec_wdata_i;
        end else if (sec_req_i) begin
          rf_re_o    = 1'b1;
          rf_raddr_o = sec_addr_i;
          state_d    = S_RESTORE;
        end
      end

      S_RESTORE: begin
        // Re-read the pipeline's last address so its dout (and bypass) is as it left it
        sec_rdata_d  = rf_rdata_i;
        sec_rvalid_d = 1'b1;
        rf_re_o      = 1'b1;
        rf_raddr_o   = last_raddr_q;
        state_d      = S_RUN;
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  assign sec_rdata_o  = sec_rdata_q;
  assign sec_rvalid_o = sec_rvalid_q;

endmodule

// File: tb/tb_mor1kx_rf_port_arbiter.sv
// Bench for mor1kx_rf_port_arbiter: a behavioural RAM drives rf_rdata_i and an
// architectural register-file array is the reference for every data check.
module tb_mor1kx_rf_port_arbiter;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_we_i, cpu_re_i, sec_req_i, sec_we_i;
  logic [AW-1:0] cpu_waddr_i, cpu_raddr_i, sec_addr_i;
  logic [DW-1:0] cpu_wdata_i, sec_wdata_i;
  logic          cpu_stall_o, sec_ack_o, sec_rvalid_o, rf_we_o, rf_re_o, busy_o;
  logic [AW-1:0] rf_waddr_o, rf_raddr_o;
  logic [DW-1:0] sec_rdata_o, rf_wdata_o, rf_rdata_i;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem    [NREG];
  logic [DW-1:0] ref_rf [NREG];
  logic [DW-1:0] dout = '0;

  always #5 clk = ~clk;

  mor1kx_rf_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_we_i(cpu_we_i), .cpu_waddr_i(cpu_waddr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_re_i(cpu_re_i), .cpu_raddr_i(cpu_raddr_i), .cpu_stall_o(cpu_stall_o),
    .sec_req_i(sec_req_i), .sec_we_i(sec_we_i), .sec_addr_i(sec_addr_i),
    .sec_wdata_i(sec_wdata_i), .sec_ack_o(sec_ack_o), .sec_rdata_o(sec_rdata_o),
    .sec_rvalid_o(sec_rvalid_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .rf_re_o(rf_re_o), .rf_raddr_o(rf_raddr_o),
    .rf_rdata_i(rf_rdata_i), .busy_o(busy_o)
  );

  // Simple dual-port RAM with registered read and write->read bypass
  always @(posedge clk) begin
    if (rf_re_o) dout <= (rf_we_o && rf_waddr_o == rf_raddr_o) ? rf_wdata_o : mem[rf_raddr_o];
    if (rf_we_o) mem[rf_waddr_o] <= rf_wdata_o;
  end
  assign rf_rdata_i = dout;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we_i = 1'b0; cpu_waddr_i = '0; cpu_wdata_i = '0;
    cpu_re_i = 1'b0; cpu_raddr_i = '0;
    sec_req_i = 1'b0; sec_we_i = 1'b0; sec_addr_i = '0; sec_wdata_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({cpu_stall_o, busy_o, sec_ack_o, sec_rvalid_o, sec_rdata_o} !== {4'b1100, DW'(0)}) begin
      miscompares++;
      $display("FAIL reset_status: stall/busy/ack/rvalid/rdata got %b%b%b%b %h want 1100 0",
               cpu_stall_o, busy_o, sec_ack_o, sec_rvalid_o, sec_rdata_o);
    end
    vectors++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, rf_re_o, rf_raddr_o} !== {1'b1, AW'(0), DW'(0), 1'b0, AW'(0)}) begin
      miscompares++;
      $display("FAIL reset_rf: we=%b waddr=%0d wdata=%h re=%b raddr=%0d want 1 0 0 0 0",
               rf_we_o, rf_waddr_o, rf_wdata_o, rf_re_o, rf_raddr_o);
    end
    next();
    rst_n = 1'b1;
    for (int i = 0; i < int'(NREG); i++) begin
      @(negedge clk);
      vectors++;
      if ({rf_we_o, rf_waddr_o, rf_wdata_o, cpu_stall_o, busy_o} !== {1'b1, AW'(i), DW'(0), 2'b11}) begin
        miscompares++;
        $display("FAIL clear_seq[%0d]: we=%b waddr=%0d wdata=%h stall=%b busy=%b want 1 %0d 0 1 1",
                 i, rf_we_o, rf_waddr_o, rf_wdata_o, cpu_stall_o, busy_o, i);
      end
      next();
    end
    @(negedge clk);
    vectors++;
    if ({cpu_stall_o, busy_o, rf_we_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL clear_done: stall=%b busy=%b we=%b want 000", cpu_stall_o, busy_o, rf_we_o);
    end
    for (int i = 0; i < int'(NREG); i++) ref_rf[i] = '0;
  endtask

  task automatic test_sec_write_idle();
    next();
    idle_inputs();
    sec_req_i = 1'b1; sec_we_i = 1'b1; sec_addr_i = AW'(9); sec_wdata_i = 32'hDEADBEEF;
    @(negedge clk);
    vectors++;
    if ({sec_ack_o, cpu_stall_o, rf_we_o, rf_waddr_o, rf_wdata_o} !== {3'b101, AW'(9), 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL sec_write_idle: ack=%b stall=%b we=%b waddr=%0d wdata=%h want 1 0 1 9 deadbeef",
               sec_ack_o, cpu_stall_o, rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    ref_rf[9] = 32'hDEADBEEF;
    next();
    sec_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sec_ack_o, rf_we_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL sec_write_release: ack=%b we=%b want 00", sec_ack_o, rf_we_o);
    end
  endtask

  task automatic test_cpu_random(input int n);
    bit pend = 1'b0;
    logic [DW-1:0] exp_rd = '0;
    for (int c = 0; c <= n; c++) begin
      next();
      idle_inputs();
      if (c < n) begin
        cpu_we_i = 1'($urandom_range(0, 1)); cpu_waddr_i = AW'($urandom_range(0, NREG - 1));
        cpu_wdata_i = DW'($urandom()); cpu_re_i = 1'($urandom_range(0, 1));
        cpu_raddr_i = AW'($urandom_range(0, NREG - 1));
      end
      @(negedge clk);
      vectors++;
      if ({rf_we_o, rf_waddr_o, rf_wdata_o, rf_re_o, rf_raddr_o, cpu_stall_o, sec_ack_o} !==
          {cpu_we_i, cpu_waddr_i, cpu_wdata_i, cpu_re_i, cpu_raddr_i, 2'b00}) begin
        miscompares++;
        $display("FAIL cpu_pass[%0d]: rf we=%b wa=%0d re=%b ra=%0d stall=%b want we=%b wa=%0d re=%b ra=%0d stall=0",
                 c, rf_we_o, rf_waddr_o, rf_re_o, rf_raddr_o, cpu_stall_o,
                 cpu_we_i, cpu_waddr_i, cpu_re_i, cpu_raddr_i);
      end
      if (pend) begin
        vectors++;
        if (rf_rdata_i !== exp_rd) begin
          miscompares++;
          $display("FAIL cpu_rdata[%0d]: got %h want %h", c, rf_rdata_i, exp_rd);
        end
      end
      if (cpu_we_i) ref_rf[cpu_waddr_i] = cpu_wdata_i;
      pend = cpu_re_i;
      exp_rd = ref_rf[cpu_raddr_i];
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] d5, d6;
    d5 = DW'($urandom());
    d6 = DW'($urandom());
    next();
    idle_inputs();
    cpu_we_i = 1'b1; cpu_waddr_i = AW'(5); cpu_wdata_i = d5;
    sec_req_i = 1'b1; sec_we_i = 1'b1; sec_addr_i = AW'(6); sec_wdata_i = d6;
    @(negedge clk);
    vectors++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, sec_ack_o, cpu_stall_o} !== {1'b1, AW'(5), d5, 2'b00}) begin
      miscompares++;
      $display("FAIL collision_cpu_wins: we=%b waddr=%0d wdata=%h ack=%b stall=%b want 1 5 %h 0 0",
               rf_we_o, rf_waddr_o, rf_wdata_o, sec_ack_o, cpu_stall_o, d5);
    end
    ref_rf[5] = d5;
    next();
    cpu_we_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, sec_ack_o, cpu_stall_o} !== {1'b1, AW'(6), d6, 2'b10}) begin
      miscompares++;
      $display("FAIL collision_sec_next: we=%b waddr=%0d wdata=%h ack=%b stall=%b want 1 6 %h 1 0",
               rf_we_o, rf_waddr_o, rf_wdata_o, sec_ack_o, cpu_stall_o, d6);
    end
    ref_rf[6] = d6;
    next();
    sec_req_i = 1'b0;
  endtask

  task automatic test_starve();
    logic [DW-1:0] dc, ds;
    dc = DW'($urandom());
    ds = DW'($urandom());
    idle_inputs();
    cpu_we_i = 1'b1; cpu_waddr_i = AW'(7); cpu_wdata_i = dc;
    sec_req_i = 1'b1; sec_we_i = 1'b1; sec_addr_i = AW'(20); sec_wdata_i = ds;
    for (int k = 1; k <= int'(LIMIT); k++) begin
      @(negedge clk);
      vectors++;
      if ({sec_ack_o, cpu_stall_o, rf_we_o, rf_waddr_o} !== {3'b001, AW'(7)}) begin
        miscompares++;
        $display("FAIL starve_deny[%0d]: ack=%b stall=%b we=%b waddr=%0d want 0 0 1 7",
                 k, sec_ack_o, cpu_stall_o, rf_we_o, rf_waddr_o);
      end
      next();
    end
    @(negedge clk);
    vectors++;
    if ({cpu_stall_o, sec_ack_o, rf_we_o, rf_waddr_o, rf_wdata_o} !== {3'b111, AW'(20), ds}) begin
      miscompares++;
      $display("FAIL starve_force: stall=%b ack=%b we=%b waddr=%0d wdata=%h want 1 1 1 20 %h",
               cpu_stall_o, sec_ack_o, rf_we_o, rf_waddr_o, rf_wdata_o, ds);
    end
    ref_rf[7] = dc;
    ref_rf[20] = ds;
    next();
    sec_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cpu_stall_o, sec_ack_o, rf_we_o, rf_waddr_o} !== {3'b001, AW'(7)}) begin
      miscompares++;
      $display("FAIL starve_replay: stall=%b ack=%b we=%b waddr=%0d want 0 0 1 7",
               cpu_stall_o, sec_ack_o, rf_we_o, rf_waddr_o);
    end
    next();
    cpu_we_i = 1'b0;
  endtask

  task automatic test_sec_read();
    idle_inputs();
    cpu_we_i = 1'b1; cpu_waddr_i = AW'(3); cpu_wdata_i = 32'h33;
    next();
    cpu_waddr_i = AW'(20); cpu_wdata_i = 32'h1234;
    next();
    ref_rf[3] = 32'h33;
    ref_rf[20] = 32'h1234;
    cpu_we_i = 1'b0; cpu_re_i = 1'b1; cpu_raddr_i = AW'(3);
    next();
    sec_req_i = 1'b1; sec_we_i = 1'b0; sec_addr_i = AW'(20);
    @(negedge clk);
    vectors++;
    if ({sec_ack_o, cpu_stall_o, rf_rdata_i} !== {2'b00, 32'h33}) begin
      miscompares++;
      $display("FAIL rd_request: ack=%b stall=%b cpu_rdata=%h want 0 0 33", sec_ack_o, cpu_stall_o, rf_rdata_i);
    end
    next();
    @(negedge clk);
    vectors++;
    if ({sec_ack_o, cpu_stall_o, rf_re_o, rf_raddr_o} !== {3'b111, AW'(20)}) begin
      miscompares++;
      $display("FAIL rd_sec: ack=%b stall=%b re=%b raddr=%0d want 1 1 1 20",
               sec_ack_o, cpu_stall_o, rf_re_o, rf_raddr_o);
    end
    next();
    sec_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sec_ack_o, cpu_stall_o, rf_re_o, rf_raddr_o, sec_rvalid_o, rf_rdata_i} !==
        {3'b011, AW'(3), 1'b0, 32'h1234}) begin
      miscompares++;
      $display("FAIL rd_restore: ack=%b stall=%b re=%b raddr=%0d rvalid=%b ram=%h want 0 1 1 3 0 1234",
               sec_ack_o, cpu_stall_o, rf_re_o, rf_raddr_o, sec_rvalid_o, rf_rdata_i);
    end
    next();
    @(negedge clk);
    vectors++;
    if ({cpu_stall_o, sec_rvalid_o, sec_rdata_o, rf_rdata_i} !== {2'b01, 32'h1234, 32'h33}) begin
      miscompares++;
      $display("FAIL rd_result: stall=%b rvalid=%b rdata=%h cpu_rdata=%h want 0 1 1234 33",
               cpu_stall_o, sec_rvalid_o, sec_rdata_o, rf_rdata_i);
    end
    next();
    cpu_re_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (sec_rvalid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_rvalid_pulse: rvalid=%b want 0", sec_rvalid_o);
    end
  endtask

  task automatic test_random_mix(input int n);
    bit pend = 1'b0, stalled = 1'b0, acked = 1'b0;
    logic [DW-1:0] exp_rd = '0, rv_exp = '0;
    int rv_at = -1, waited = 0;
    for (int c = 0; c < n; c++) begin
      next();
      if (!stalled) begin
        cpu_we_i = (c < n - 20) ? 1'($urandom_range(0, 9) < 7) : 1'b0;
        cpu_waddr_i = AW'($urandom_range(0, NREG - 1)); cpu_wdata_i = DW'($urandom());
        cpu_re_i = 1'($urandom_range(0, 1)); cpu_raddr_i = AW'($urandom_range(0, NREG - 1));
      end
      if (acked) begin
        sec_req_i = 1'b0;
      end else if (!sec_req_i && c < n - 20 && $urandom_range(0, 4) == 0) begin
        sec_req_i = 1'b1; sec_we_i = 1'($urandom_range(0, 1));
        sec_addr_i = AW'($urandom_range(0, NREG - 1)); sec_wdata_i = DW'($urandom());
        waited = 0;
      end
      @(negedge clk);
      vectors++;
      if (sec_ack_o && !sec_req_i) begin
        miscompares++;
        $display("FAIL mix_ack_noreq[%0d]: ack=1 without request", c);
      end
      if (!cpu_stall_o && pend) begin
        vectors++;
        if (rf_rdata_i !== exp_rd) begin
          miscompares++;
          $display("FAIL mix_cpu_rdata[%0d]: got %h want %h", c, rf_rdata_i, exp_rd);
        end
        pend = 1'b0;
      end
      vectors++;
      if (rv_at == c) begin
        if ({sec_rvalid_o, sec_rdata_o, cpu_stall_o} !== {1'b1, rv_exp, 1'b0}) begin
          miscompares++;
          $display("FAIL mix_sec_rdata[%0d]: rvalid=%b rdata=%h stall=%b want 1 %h 0",
                   c, sec_rvalid_o, sec_rdata_o, cpu_stall_o, rv_exp);
        end
      end else if (sec_rvalid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL mix_rvalid_spurious[%0d]: rvalid=%b want 0", c, sec_rvalid_o);
      end
      if (!cpu_stall_o && cpu_we_i) ref_rf[cpu_waddr_i] = cpu_wdata_i;
      if (sec_ack_o && sec_we_i) ref_rf[sec_addr_i] = sec_wdata_i;
      if (sec_ack_o && !sec_we_i) begin
        rv_at = c + 2;
        rv_exp = ref_rf[sec_addr_i];
      end
      if (!cpu_stall_o && cpu_re_i) begin
        pend = 1'b1;
        exp_rd = ref_rf[cpu_raddr_i];
      end
      if (sec_req_i && !sec_ack_o) begin
        waited++;
        if (waited == int'(LIMIT) + 2) begin
          vectors++;
          miscompares++;
          $display("FAIL mix_starved[%0d]: request waited %0d cycles, limit %0d", c, waited, LIMIT + 1);
        end
      end
      stalled = cpu_stall_o;
      acked = sec_ack_o;
    end
    next();
    idle_inputs();
  endtask

  task automatic test_readback();
    for (int i = 0; i <= int'(NREG); i++) begin
      cpu_re_i = (i < int'(NREG));
      cpu_raddr_i = AW'(i);
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if (rf_rdata_i !== ref_rf[i - 1]) begin
          miscompares++;
          $display("FAIL readback[%0d]: got %h want %h", i - 1, rf_rdata_i, ref_rf[i - 1]);
        end
      end
      next();
    end
    cpu_re_i = 1'b0;
  endtask

  task automatic test_reset_mid_sec();
    next();
    idle_inputs();
    sec_req_i = 1'b1; sec_we_i = 1'b0; sec_addr_i = AW'(20);
    @(negedge clk);
    next();
    vectors++;
    if ({sec_ack_o, cpu_stall_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL abort_in_sec: ack=%b stall=%b want 11", sec_ack_o, cpu_stall_o);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({sec_ack_o, cpu_stall_o, busy_o, sec_rvalid_o, sec_rdata_o, rf_we_o, rf_waddr_o, rf_re_o} !==
        {4'b0110, DW'(0), 1'b1, AW'(0), 1'b0}) begin
      miscompares++;
      $display("FAIL abort_outputs: ack=%b stall=%b busy=%b rvalid=%b rdata=%h we=%b waddr=%0d re=%b",
               sec_ack_o, cpu_stall_o, busy_o, sec_rvalid_o, sec_rdata_o, rf_we_o, rf_waddr_o, rf_re_o);
    end
    sec_req_i = 1'b0;
    repeat (2) next();
    rst_n = 1'b1;
    for (int i = 0; i < int'(NREG); i++) begin
      @(negedge clk);
      vectors++;
      if ({rf_we_o, rf_waddr_o, rf_wdata_o, cpu_stall_o, sec_rvalid_o, sec_ack_o} !==
          {1'b1, AW'(i), DW'(0), 3'b100}) begin
        miscompares++;
        $display("FAIL abort_clear[%0d]: we=%b waddr=%0d wdata=%h stall=%b rvalid=%b ack=%b want 1 %0d 0 1 0 0",
                 i, rf_we_o, rf_waddr_o, rf_wdata_o, cpu_stall_o, sec_rvalid_o, sec_ack_o, i);
      end
      next();
    end
    for (int i = 0; i < int'(NREG); i++) ref_rf[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(NREG); i++) mem[i] = DW'($urandom());
    test_reset();
    test_readback();
    test_sec_write_idle();
    test_cpu_random(200);
    test_collision();
    test_starve();
    test_sec_read();
    test_random_mix(600);
    test_readback();
    test_reset_mid_sec();
    test_readback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
